// File: rtl/ibex_ifq_pkg.sv
// ibex_ifq_pkg: shared types and constants for the IF/ID instruction queue.
package ibex_ifq_pkg;

    localparam int unsigned IFQ_MAX_DEPTH  = 16;
    localparam int unsigned IFQ_RDATA_C_W  = 16;
    localparam int unsigned IFQ_MAX_ADDR_W = 32;

    typedef struct packed {
        logic [IFQ_MAX_ADDR_W-1:0] pc;
        logic [31:0]               rdata;
        logic [IFQ_RDATA_C_W-1:0]  rdata_c;
        logic                      is_compressed;
        logic                      illegal_c;
        logic                      err;
    } ifq_entry_t;

    // A single-entry queue still needs a 1-bit pointer.
    function automatic int unsigned ifq_ptr_w(input int unsigned depth);
        return depth > 1 ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ibex_ifq_ptr.sv
// ibex_ifq_ptr: queue pointer that wraps from DEPTH-1 to 0, so any DEPTH works.
module ibex_ifq_ptr
    import ibex_ifq_pkg::*;
#(
    parameter int unsigned  DEPTH = 2,
    localparam int unsigned PTR_W = ifq_ptr_w(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc,
    input  logic             clr,
    output logic [PTR_W-1:0] ptr
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr <= '0;
        else if (clr) ptr <= '0;
        else if (inc) ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    end

endmodule

// File: rtl/ibex_if_id_queue.sv
// ibex_if_id_queue: DEPTH-entry IF/ID instruction queue; IBEX_IFQ_BYPASS_EN adds empty-queue pass-through.
module ibex_if_id_queue
    import ibex_ifq_pkg::*;
#(
    parameter int unsigned  DEPTH  = 2,
    parameter int unsigned  ADDR_W = 32,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [ADDR_W-1:0]        in_pc_i,
    input  logic [31:0]              in_rdata_i,
    input  logic [IFQ_RDATA_C_W-1:0] in_rdata_c_i,
    input  logic                     in_is_compressed_i,
    input  logic                     in_illegal_c_i,
    input  logic                     in_err_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [ADDR_W-1:0]        out_pc_o,
    output logic [31:0]              out_rdata_o,
    output logic [IFQ_RDATA_C_W-1:0] out_rdata_c_o,
    output logic                     out_is_compressed_o,
    output logic                     out_illegal_c_o,
    output logic                     out_err_o,
    output logic                     out_new_o,
    output logic [CNT_W-1:0]         occupancy_o,
    output logic                     busy_o
);

    localparam int unsigned PTR_W = ifq_ptr_w(DEPTH);

    if (DEPTH < 1 || DEPTH > IFQ_MAX_DEPTH || ADDR_W > IFQ_MAX_ADDR_W) begin : g_bad_param
        $error("ibex_if_id_queue: DEPTH must be 1..16 and ADDR_W at most 32");
    end

    ifq_entry_t       mem_q [DEPTH];
    ifq_entry_t       in_entry, head;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             presented_q, empty, full, byp, push, pop, store, take;

    assign in_entry = '{
        pc:            IFQ_MAX_ADDR_W'(in_pc_i),
        rdata:         in_rdata_i,
        rdata_c:       in_rdata_c_i,
        is_compressed: in_is_compressed_i,
        illegal_c:     in_illegal_c_i,
        err:           in_err_i
    };

    assign empty = count_q == '0;
    assign full  = count_q == CNT_W'(DEPTH);

`ifdef IBEX_IFQ_BYPASS_EN
    assign byp = empty & in_valid_i & ~flush_i;
`else
    assign byp = 1'b0;
`endif

    assign in_ready_o  = ~full & ~flush_i;
    assign out_valid_o = (~empty | byp) & ~flush_i;
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;
    // A bypassed instruction consumed this cycle is never written to storage.
    assign store       = push & ~(byp & out_ready_i);
    assign take        = pop & ~byp;

    assign head                = byp ? in_entry : mem_q[rd_ptr];
    assign out_pc_o            = head.pc[ADDR_W-1:0];
    assign out_rdata_o         = head.rdata;
    assign out_rdata_c_o       = head.rdata_c;
    assign out_is_compressed_o = head.is_compressed;
    assign out_illegal_c_o     = head.illegal_c;
    assign out_err_o           = head.err;
    assign out_new_o           = out_valid_o & ~presented_q;
    assign occupancy_o         = count_q;
    assign busy_o              = ~empty;

    ibex_ifq_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc    (store),
        .clr    (flush_i),
        .ptr    (wr_ptr)
    );

    ibex_ifq_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc    (take),
        .clr    (flush_i),
        .ptr    (rd_ptr)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) count_q <= '0;
        else if (flush_i) count_q <= '0;
        else if (store & ~take) count_q <= count_q + CNT_W'(1);
        else if (take & ~store) count_q <= count_q - CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) presented_q <= 1'b0;
        else if (flush_i | pop) presented_q <= 1'b0;
        else if (out_valid_o & ~out_ready_i) presented_q <= 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (store) begin
            mem_q[wr_ptr] <= in_entry;
        end
    end

endmodule

// File: tb/tb_ibex_if_id_queue.sv
// tb_ibex_if_id_queue: directed checks of the IF/ID queue at DEPTH=2 (instance a) and DEPTH=3 (instance b).
module tb_ibex_if_id_queue;

`ifdef IBEX_IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0;
    logic        in_valid_i = 1'b0, out_ready_i = 1'b0;
    logic [31:0] in_pc_i = '0, in_rdata_i = '0;
    logic [15:0] in_rdata_c_i = '0;
    logic        in_is_compressed_i = 1'b0, in_illegal_c_i = 1'b0, in_err_i = 1'b0;

    logic        a_in_ready, a_valid, a_comp, a_ill, a_err, a_new, a_busy;
    logic [31:0] a_pc, a_rdata;
    logic [15:0] a_rdc;
    logic [1:0]  a_occ;
    logic        b_in_ready, b_valid, b_comp, b_ill, b_err, b_new, b_busy;
    logic [31:0] b_pc, b_rdata;
    logic [15:0] b_rdc;
    logic [1:0]  b_occ;

    int checks = 0, failures = 0;

    always #5 clk_i = ~clk_i;

    ibex_if_id_queue #(.DEPTH(2)) u_a (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(a_in_ready), .in_pc_i(in_pc_i),
        .in_rdata_i(in_rdata_i), .in_rdata_c_i(in_rdata_c_i),
        .in_is_compressed_i(in_is_compressed_i), .in_illegal_c_i(in_illegal_c_i), .in_err_i(in_err_i),
        .out_valid_o(a_valid), .out_ready_i(out_ready_i), .out_pc_o(a_pc),
        .out_rdata_o(a_rdata), .out_rdata_c_o(a_rdc), .out_is_compressed_o(a_comp),
        .out_illegal_c_o(a_ill), .out_err_o(a_err), .out_new_o(a_new),
        .occupancy_o(a_occ), .busy_o(a_busy)
    );

    ibex_if_id_queue #(.DEPTH(3)) u_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(b_in_ready), .in_pc_i(in_pc_i),
        .in_rdata_i(in_rdata_i), .in_rdata_c_i(in_rdata_c_i),
        .in_is_compressed_i(in_is_compressed_i), .in_illegal_c_i(in_illegal_c_i), .in_err_i(in_err_i),
        .out_valid_o(b_valid), .out_ready_i(out_ready_i), .out_pc_o(b_pc),
        .out_rdata_o(b_rdata), .out_rdata_c_o(b_rdc), .out_is_compressed_o(b_comp),
        .out_illegal_c_o(b_ill), .out_err_o(b_err), .out_new_o(b_new),
        .occupancy_o(b_occ), .busy_o(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic drv(input logic v, input logic [31:0] pc);
        in_valid_i = v;
        in_pc_i    = pc;
    endtask

    initial begin
        #3;
        chk("rst_valid", a_valid, 0);
        chk("rst_new", a_new, 0);
        chk("rst_occ", a_occ, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_pc", a_pc, 0);
        chk("rst_rdata", a_rdata, 0);
        @(negedge clk_i) rst_ni = 1'b1;
        tick();

        // Fill DEPTH=2 with the consumer stalled
        drv(1, 32'h80);
        in_rdata_i = 32'h13; in_rdata_c_i = 16'h4082; in_is_compressed_i = 1; in_err_i = 1;
        #1 chk("fill_in_ready0", a_in_ready, 1);
        tick();
        drv(1, 32'h84);
        in_rdata_i = 32'h00400093; in_rdata_c_i = '0; in_is_compressed_i = 0; in_err_i = 0;
        #1 chk("fill_valid", a_valid, 1);
        chk("fill_head0", a_pc, 32'h80);
        chk("fill_new0", a_new, !BYP);
        chk("fill_comp0", a_comp, 1);
        chk("fill_rdc0", a_rdc, 32'h4082);
        chk("fill_err0", a_err, 1);
        tick();
        drv(0, 32'h0);
        #1 chk("full_occ", a_occ, 2);
        chk("full_in_ready", a_in_ready, 0);
        chk("full_new", a_new, 0);
        chk("full_head", a_pc, 32'h80);
        out_ready_i = 1;
        #1 chk("drain_head0", a_pc, 32'h80);
        tick();
        chk("drain_occ1", a_occ, 1);
        chk("drain_head1", a_pc, 32'h84);
        chk("drain_rdata1", a_rdata, 32'h00400093);
        chk("drain_new1", a_new, 1);
        chk("drain_err1", a_err, 0);
        tick();
        chk("drain_occ0", a_occ, 0);
        chk("drain_busy0", a_busy, 0);
        chk("drain_valid0", a_valid, 0);

        // Simultaneous push and pop at count 1
        out_ready_i = 0;
        drv(1, 32'h100);
        tick();
        drv(1, 32'h104);
        out_ready_i = 1;
        #1 chk("pp_head", a_pc, 32'h100);
        chk("pp_new", a_new, !BYP);
        chk("pp_in_ready", a_in_ready, 1);
        tick();
        drv(0, 32'h0);
        out_ready_i = 0;
        #1 chk("pp_occ", a_occ, 1);
        chk("pp_next_head", a_pc, 32'h104);
        chk("pp_next_new", a_new, 1);

        // Flush with two entries stored and a push attempted
        drv(1, 32'h108);
        tick();
        flush_i = 1;
        drv(1, 32'h200);
        out_ready_i = 1;
        #1 chk("fl_pre_occ", a_occ, 2);
        chk("fl_in_ready", a_in_ready, 0);
        chk("fl_valid", a_valid, 0);
        chk("fl_new", a_new, 0);
        tick();
        flush_i = 0;
        drv(0, 32'h0);
        out_ready_i = 0;
        #1 chk("fl_occ", a_occ, 0);
        chk("fl_valid_after", a_valid, 0);
        chk("fl_busy", a_busy, 0);
        drv(1, 32'h204);
        tick();
        drv(0, 32'h0);
        #1 chk("fl_repush_occ", a_occ, 1);
        chk("fl_repush_head", a_pc, 32'h204);

        // Asynchronous reset in the middle of a cycle
        drv(1, 32'h208);
        tick();
        drv(0, 32'h0);
        #1 chk("ar_pre_occ", a_occ, 2);
        rst_ni = 0;
        #1 chk("ar_valid", a_valid, 0);
        chk("ar_occ", a_occ, 0);
        chk("ar_in_ready", a_in_ready, 1);
        chk("ar_busy", a_busy, 0);
        chk("ar_pc", a_pc, 0);
        @(negedge clk_i) rst_ni = 1'b1;
        tick();

        // DEPTH=3: preload two entries, then seven pops against five more pushes
        drv(1, 32'h0);
        tick();
        drv(1, 32'h4);
        tick();
        chk("wrap_preload_occ", b_occ, 2);
        out_ready_i = 1;
        for (int i = 2; i < 9; i++) begin
            drv(i < 7, 32'(4 * i));
            #1 chk("wrap_valid", b_valid, 1);
            chk("wrap_head", b_pc, 32'(4 * (i - 2)));
            tick();
        end
        drv(0, 32'h0);
        out_ready_i = 0;
        #1 chk("wrap_occ_end", b_occ, 0);
        chk("wrap_valid_end", b_valid, 0);

        // Empty queue with an arriving instruction and a ready consumer
        in_rdata_i = 32'h00000013;
        drv(1, 32'h300);
        out_ready_i = 1;
`ifdef IBEX_IFQ_BYPASS_EN
        #1 chk("byp_valid", a_valid, 1);
        chk("byp_pc", a_pc, 32'h300);
        chk("byp_rdata", a_rdata, 32'h13);
        chk("byp_new", a_new, 1);
        tick();
        drv(0, 32'h0);
        #1 chk("byp_occ", a_occ, 0);
`else
        #1 chk("nobyp_valid", a_valid, 0);
        chk("nobyp_in_ready", a_in_ready, 1);
        tick();
        drv(0, 32'h0);
        #1 chk("nobyp_occ", a_occ, 1);
        chk("nobyp_pc", a_pc, 32'h300);
        chk("nobyp_rdata", a_rdata, 32'h13);
        chk("nobyp_new", a_new, 1);
        tick();
        chk("nobyp_occ_end", a_occ, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
